addsub_accumulator: RTL and testbench
=====================================

Name: addsub_accumulator

Overview:
- Sequential accumulator stage wrapped around a 4-bit-class adder/subtractor datapath.
- Accepts one command per handshake (ADD, SUB, LOAD, CLR, MUL) and applies the operand against an internal accumulator.
- MUL is computed by iterative shift-and-add.
- Result and flags are registered and presented on a valid/ready output channel to the downstream consumer.

Parameters:
- WIDTH, 4, accumulator/operand width in bits (>=2)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  command valid
- in_ready  output  1  block can accept a command (high only in IDLE)
- op  input  3  000 ADD, 001 SUB, 010 LOAD, 011 CLR, 100 MUL, others NOP
- operand  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- acc  output  WIDTH  accumulator value (registered)
- carry  output  1  ADD: carry-out; SUB: 1 = no borrow; MUL: product >= 2^WIDTH
- ovf  output  1  two's-complement overflow (ADD/SUB only)
- busy  output  1  high while in MUL state

Behaviour:
- Interface: one clock (clk), asynchronous active-high reset (rst). Already decided.
- Reset values: acc=0, carry=0, ovf=0, out_valid=0, busy=0, state=IDLE. in_ready=1 while rst is asserted and after release.
- States:
  - IDLE: in_ready=1. Accept on in_valid at edge E0.
  - MUL: busy=1, in_ready=0.
  - RESP: out_valid=1, in_ready=0. Leave on out_ready=1 and return to IDLE.
- Single-cycle ops (ADD, SUB, LOAD, CLR, NOP) execute at E0 and enter RESP. out_valid=1 from E0.
- ADD: acc <= acc+operand mod 2^WIDTH; carry = carry-out; ovf = (acc[msb]==operand[msb]) && (res[msb]!=acc[msb]).
- SUB: computed as acc + ~operand + 1; carry = carry-out; ovf = (acc[msb]!=operand[msb]) && (res[msb]!=acc[msb]).
- LOAD: acc <= operand; carry=0, ovf=0.
- CLR: acc <= 0; carry=0, ovf=0.
- NOP (unused op codes): acc, carry and ovf unchanged; a response is still produced.
- MUL:
  - At E0, capture mcand = acc zero-extended to 2*WIDTH bits, mplier = operand, prod = 0, cnt = 0. Enter MUL.
  - Each MUL edge: if mplier[0], prod += mcand; then mcand <<= 1, mplier >>= 1, cnt++.
  - On the edge where cnt == WIDTH-1: acc <= prod[WIDTH-1:0] (including that step's add), carry = |prod[2W-1:W], ovf=0. Enter RESP.
  - out_valid=1 from edge E0+WIDTH.
- RESP: acc, carry and ovf are held stable until the transfer completes; in_valid is ignored.
  - Transfer at edge with out_valid && out_ready.
  - No same-cycle pass-through: minimum 2 cycles per single op, WIDTH+1 per MUL.
- Reset mid-operation (any state): immediate abort, no response, all outputs to reset values.
- Operand is sampled only at E0. Later changes to operand have no effect.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined:
  - ADD with carry=1 gives acc = all ones.
  - SUB with carry=0 (borrow) gives acc = 0.
  - MUL with carry=1 gives acc = all ones.
  - carry and ovf report as normal.
- Undefined: all results wrap modulo 2^WIDTH.

Decomposition:
- Package addsub_pkg holds:
  - op_t enum (OP_ADD, OP_SUB, OP_LOAD, OP_CLR, OP_MUL)
  - state_t enum (IDLE, MUL, RESP)
  - default WIDTH constant
- Sub-module addsub_core: combinational WIDTH-bit adder/subtractor.
  - Inputs: a, b, k (k=1 subtracts via b^k and carry-in k).
  - Outputs: sum, cout, ovf.
  - Used for ADD/SUB. The MUL step uses its own 2*WIDTH-bit adder.

Test Plan (WIDTH=4):
- Reset, LOAD 5, ADD 3 -> acc=8, carry=0, ovf=1; out_valid in the cycle after accept.
- LOAD 3, SUB 5 -> acc=14, carry=0 (borrow), ovf=0. Then SUB 2 -> acc=12, carry=1, ovf=0.
- LOAD 6, MUL 3 -> busy high for 4 cycles; out_valid rises 4 edges after accept; acc=2, carry=1. Also LOAD 3, MUL 5 -> acc=15, carry=0.
- Backpressure: hold out_ready=0 for 3 cycles after ADD -> out_valid, acc and flags stable; in_ready=0; in_valid pulses ignored. Then out_ready=1 -> IDLE, in_ready=1 next cycle.
- Reset mid-MUL: assert rst 2 cycles after MUL accept -> acc=0, out_valid=0, busy=0, in_ready=1 without waiting for a clock edge; no response emitted.
- With ADDSUB_SATURATE_EN: LOAD 12, ADD 7 -> acc=15, carry=1. LOAD 2, SUB 5 -> acc=0, carry=0. Without the macro the same sequences give acc=3 and acc=13.

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared op codes, FSM states and default width
// for the add/sub accumulator slice.
package addsub_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_LOAD = 3'b010,
    OP_CLR  = 3'b011,
    OP_MUL  = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_t;

endpackage

// File: rtl/addsub_core.sv
// addsub_core: combinational WIDTH-bit adder/subtractor.
// k=1 subtracts by inverting b and injecting a carry-in.
module addsub_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             k,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] bx;

  assign bx = b ^ {WIDTH{k}};
  assign {cout, sum} = {1'b0, a} + {1'b0, bx}
                     + {{WIDTH{1'b0}}, k};
  assign ovf = (a[WIDTH-1] == bx[WIDTH-1])
            && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_accumulator.sv
// addsub_accumulator: handshaked accumulator with ADD/SUB/LOAD/CLR/MUL.
// Define ADDSUB_SATURATE_EN to clamp ADD/SUB/MUL results instead of wrapping.
module addsub_accumulator
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  state_t state, state_nxt;

  logic [W2-1:0]    mcand;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    prod_nxt;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] as_sum;
  logic [WIDTH-1:0] as_res;
  logic [WIDTH-1:0] mul_res;
  logic             as_cout;
  logic             as_ovf;
  logic             mul_hi;
  logic             mul_last;
  logic             accept;

  logic is_add, is_sub, is_load, is_clr, is_mul;

  assign is_add  = (op == OP_ADD);
  assign is_sub  = (op == OP_SUB);
  assign is_load = (op == OP_LOAD);
  assign is_clr  = (op == OP_CLR);
  assign is_mul  = (op == OP_MUL);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);
  assign busy      = (state == MUL);
  assign accept    = in_ready && in_valid;

  addsub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a    (acc),
    .b    (operand),
    .k    (is_sub),
    .sum  (as_sum),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  assign prod_nxt = mplier[0] ? prod + mcand : prod;
  assign mul_hi   = |prod_nxt[W2-1:WIDTH];
  assign mul_last = (cnt == CW'(WIDTH - 1));

`ifdef ADDSUB_SATURATE_EN
  assign as_res  = is_sub
                 ? (as_cout ? as_sum : '0)
                 : (as_cout ? '1 : as_sum);
  assign mul_res = mul_hi ? '1 : prod_nxt[WIDTH-1:0];
`else
  assign as_res  = as_sum;
  assign mul_res = prod_nxt[WIDTH-1:0];
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: single ops go straight to RESP, MUL iterates first
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = is_mul ? MUL : RESP;
      MUL:  if (mul_last) state_nxt = RESP;
      RESP: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, flags and shift-and-add multiplier registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (accept) begin
      unique case (1'b1)
        is_add, is_sub: begin
          acc   <= as_res;
          carry <= as_cout;
          ovf   <= as_ovf;
        end
        is_load: begin
          acc   <= operand;
          carry <= 1'b0;
          ovf   <= 1'b0;
        end
        is_clr: begin
          acc   <= '0;
          carry <= 1'b0;
          ovf   <= 1'b0;
        end
        is_mul: begin
          mcand  <= {{WIDTH{1'b0}}, acc};
          mplier <= operand;
          prod   <= '0;
          cnt    <= '0;
        end
        default: ;
      endcase
    end else if (state == MUL) begin
      prod   <= prod_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (mul_last) begin
        acc   <= mul_res;
        carry <= mul_hi;
        ovf   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_addsub_accumulator.sv
// tb_addsub_accumulator: randomized and directed checks of the
// accumulator against an arithmetic reference model.
module tb_addsub_accumulator;

  localparam int W   = 4;
  localparam int MOD = 1 << W;
  localparam int SMX = (1 << (W - 1)) - 1;
  localparam int SMN = -(1 << (W - 1));

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] operand;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] acc;
  logic         carry;
  logic         ovf;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  int m_acc;
  bit m_c;
  bit m_v;

  int lat;
  int busy_cnt;
  bit timed_out;
  bit acc_ok;

  always #5 clk = ~clk;

  addsub_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand   (operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .carry     (carry),
    .ovf       (ovf),
    .busy      (busy)
  );

  function automatic int sgn(int x);
    return (x > SMX) ? x - MOD : x;
  endfunction

  // Reference: plain integer arithmetic on the accumulator value
  function automatic void model(int o, int b);
    int r;
    int s;
    case (o)
      0: begin
        r   = m_acc + b;
        s   = sgn(m_acc) + sgn(b);
        m_c = (r >= MOD);
        m_v = (s > SMX) || (s < SMN);
        r   = r % MOD;
`ifdef ADDSUB_SATURATE_EN
        if (m_c) r = MOD - 1;
`endif
        m_acc = r;
      end
      1: begin
        r   = m_acc - b;
        s   = sgn(m_acc) - sgn(b);
        m_c = (m_acc >= b);
        m_v = (s > SMX) || (s < SMN);
        r   = (r + MOD) % MOD;
`ifdef ADDSUB_SATURATE_EN
        if (!m_c) r = 0;
`endif
        m_acc = r;
      end
      2: begin m_acc = b; m_c = 0; m_v = 0; end
      3: begin m_acc = 0; m_c = 0; m_v = 0; end
      4: begin
        r   = m_acc * b;
        m_c = (r >= MOD);
        m_v = 0;
        r   = r % MOD;
`ifdef ADDSUB_SATURATE_EN
        if (m_c) r = MOD - 1;
`endif
        m_acc = r;
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] b);
    @(negedge clk);
    acc_ok   = in_ready;
    in_valid = 1'b1;
    op       = o;
    operand  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 3'($urandom);
    operand  = W'($urandom);
    model(int'(o), int'(b));
    lat      = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 50) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    timed_out = !out_valid;
  endtask

  task automatic finish_resp();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (acc !== 0 || carry !== 0 || ovf !== 0 || out_valid !== 0
        || busy !== 0 || in_ready !== 1) begin
      failures++;
      $display("FAIL reset_hold acc=%0d c=%b v=%b ov=%b b=%b ir=%b exp 0/0/0/0/0/1",
               acc, carry, ovf, out_valid, busy, in_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_acc = 0; m_c = 0; m_v = 0;
    @(posedge clk);
    #1;
    checks++;
    if (acc !== 0 || out_valid !== 0 || in_ready !== 1) begin
      failures++;
      $display("FAIL reset_release acc=%0d ov=%b ir=%b exp 0/0/1",
               acc, out_valid, in_ready);
    end
  endtask

  task automatic test_add_sub();
    logic [2:0] ops [5] = '{3'd2, 3'd0, 3'd2, 3'd1, 3'd1};
    logic [W-1:0] vals [5] = '{4'd5, 4'd3, 4'd3, 4'd5, 4'd2};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], vals[i]);
      checks++;
      if (timed_out || !acc_ok || lat !== 0) begin
        failures++;
        $display("FAIL addsub_lat step=%0d lat=%0d to=%b rdy=%b exp lat 0",
                 i, lat, timed_out, acc_ok);
      end
      checks++;
      if (acc !== W'(m_acc) || carry !== m_c || ovf !== m_v) begin
        failures++;
        $display("FAIL addsub_res step=%0d got %0d/%b/%b exp %0d/%b/%b",
                 i, acc, carry, ovf, m_acc, m_c, m_v);
      end
      finish_resp();
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] a [2] = '{4'd6, 4'd3};
    logic [W-1:0] b [2] = '{4'd3, 4'd5};
    for (int i = 0; i < 2; i++) begin
      run_op(3'd2, a[i]);
      finish_resp();
      run_op(3'd4, b[i]);
      checks++;
      if (timed_out || lat !== W || busy_cnt !== W) begin
        failures++;
        $display("FAIL mul_timing i=%0d lat=%0d busy=%0d exp %0d/%0d",
                 i, lat, busy_cnt, W, W);
      end
      checks++;
      if (acc !== W'(m_acc) || carry !== m_c || ovf !== 1'b0) begin
        failures++;
        $display("FAIL mul_res i=%0d got %0d/%b/%b exp %0d/%b/0",
                 i, acc, carry, ovf, m_acc, m_c);
      end
      finish_resp();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] h_acc;
    logic         h_c;
    logic         h_v;
    run_op(3'd0, W'($urandom));
    h_acc = W'(m_acc);
    h_c   = m_c;
    h_v   = m_v;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op       = 3'd2;
      operand  = W'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1 || in_ready !== 0 || acc !== h_acc
          || carry !== h_c || ovf !== h_v) begin
        failures++;
        $display("FAIL bp_hold i=%0d ov=%b ir=%b got %0d/%b/%b exp %0d/%b/%b",
                 i, out_valid, in_ready, acc, carry, ovf, h_acc, h_c, h_v);
      end
    end
    in_valid = 1'b0;
    finish_resp();
    checks++;
    if (in_ready !== 1 || out_valid !== 0) begin
      failures++;
      $display("FAIL bp_release ir=%b ov=%b exp 1/0", in_ready, out_valid);
    end
    run_op(3'd0, 4'd1);
    checks++;
    if (acc !== W'(m_acc)) begin
      failures++;
      $display("FAIL bp_after acc=%0d exp %0d", acc, m_acc);
    end
    finish_resp();
  endtask

  task automatic test_random();
    logic [2:0]   o;
    logic [W-1:0] b;
    int           el;
    for (int i = 0; i < 40; i++) begin
      o  = 3'($urandom_range(0, 7));
      b  = W'($urandom);
      el = (o == 3'd4) ? W : 0;
      run_op(o, b);
      checks++;
      if (timed_out || lat !== el) begin
        failures++;
        $display("FAIL rand_lat i=%0d op=%0d lat=%0d exp %0d", i, o, lat, el);
      end
      checks++;
      if (acc !== W'(m_acc) || carry !== m_c || ovf !== m_v) begin
        failures++;
        $display("FAIL rand_res i=%0d op=%0d b=%0d got %0d/%b/%b exp %0d/%b/%b",
                 i, o, b, acc, carry, ovf, m_acc, m_c, m_v);
      end
      finish_resp();
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    run_op(3'd2, 4'd7);
    finish_resp();
    @(negedge clk);
    in_valid = 1'b1;
    op       = 3'd4;
    operand  = 4'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy !== 1) begin
      failures++;
      $display("FAIL mid_mul_busy busy=%b exp 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (acc !== 0 || out_valid !== 0 || busy !== 0 || in_ready !== 1
        || carry !== 0 || ovf !== 0) begin
      failures++;
      $display("FAIL mid_mul_rst acc=%0d ov=%b b=%b ir=%b exp 0/0/0/1",
               acc, out_valid, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    m_acc = 0; m_c = 0; m_v = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL mid_mul_noresp out_valid_cycles=%0d exp 0", seen);
    end
  endtask

  task automatic test_saturate();
    logic [2:0] ops [4] = '{3'd2, 3'd0, 3'd2, 3'd1};
    logic [W-1:0] vals [4] = '{4'd12, 4'd7, 4'd2, 4'd5};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], vals[i]);
      checks++;
      if (timed_out || acc !== W'(m_acc) || carry !== m_c || ovf !== m_v) begin
        failures++;
        $display("FAIL sat_seq i=%0d got %0d/%b/%b exp %0d/%b/%b",
                 i, acc, carry, ovf, m_acc, m_c, m_v);
      end
      finish_resp();
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 3'd0;
    operand   = '0;
    test_reset();
    test_add_sub();
    test_mul();
    test_backpressure();
    test_saturate();
    test_random();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
